// File: rtl/sim_status_mmio_pkg.sv
// Shared definitions for the simulation status/console peripheral: register
// offsets, the termination state encoding and the STATUS word layout.
package sim_status_pkg;

    localparam logic [3:0] OFF_TOHOST = 4'h0;
    localparam logic [3:0] OFF_CHAR   = 4'h4;
    localparam logic [3:0] OFF_CYCLE  = 4'h8;
    localparam logic [3:0] OFF_STATUS = 4'hC;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_DONE_PASS = 2'd1,
        ST_DONE_FAIL = 2'd2,
        ST_TIMEOUT   = 2'd3
    } state_e;

    localparam int STAT_DONE     = 0;
    localparam int STAT_PASS     = 1;
    localparam int STAT_FAIL     = 2;
    localparam int STAT_TIMEOUT  = 3;
    localparam int STAT_CNT_LSB  = 4;
    localparam int STAT_CNT_W    = 5;
    localparam int STAT_OVERFLOW = 9;

    function automatic logic [31:0] pack_status(
        input logic       done,
        input logic       pass,
        input logic       fail,
        input logic       tmo,
        input logic       ovf,
        input logic [4:0] cnt
    );
        logic [31:0] w;
        w = '0;
        w[STAT_DONE]                       = done;
        w[STAT_PASS]                       = pass;
        w[STAT_FAIL]                       = fail;
        w[STAT_TIMEOUT]                    = tmo;
        w[STAT_CNT_LSB +: STAT_CNT_W]      = cnt;
        w[STAT_OVERFLOW]                   = ovf;
        return w;
    endfunction

endpackage

// File: rtl/sim_status_mmio_sync_fifo.sv
// Single-clock FIFO with occupancy count. A push into a full FIFO is accepted
// only when a pop happens in the same cycle; otherwise it is dropped and flagged.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     ready_i,
    output logic                     valid_o,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     drop_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full;
    logic             pop;
    logic             push_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign pop     = ready_i && (count_q != '0);
    assign push_ok = push_i && (!full || pop);
    assign drop_o  = push_i && full && !pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
        end
    end

    // Head is masked when empty so a drained or reset FIFO presents zero.
    assign valid_o = (count_q != '0);
    assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/sim_status_mmio.sv
// Store-bus status/console peripheral: sticky pass/fail/timeout termination,
// run-cycle counter, and a buffered character stream with valid/ready output.
module sim_status_mmio
    import sim_status_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'hFFFF_FF00,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned FIFO_DEPTH     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_write,
    input  logic [31:0] data_addr,
    input  logic [31:0] write_data,
    output logic [31:0] rd_data,
    output logic        rd_hit,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [30:0] fail_code,
    output logic [31:0] cycle_count,
    output logic        char_valid,
    output logic [7:0]  char_data,
    input  logic        char_ready,
    output logic        overflow
);

    localparam int          CW         = $clog2(FIFO_DEPTH) + 1;
    localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] TO_LAST    = TIMEOUT_CYCLES - 1;

    state_e         state_q, state_d;
    logic [30:0]    fail_code_q, fail_code_d;
    logic [31:0]    cycle_q, cycle_d;
    logic           overflow_q, overflow_d;

    logic [31:0]    off_full;
    logic [3:0]     reg_off;
    logic           wr_hit;
    logic           tohost_wr;
    logic           char_wr;

    logic [CW-1:0]  fifo_count;
    logic           fifo_drop;
    logic [4:0]     cnt5;

    // Subtracting the base keeps the decode correct for any word-aligned base,
    // including windows that straddle a 16-byte boundary.
    assign off_full  = data_addr - BASE_ADDR;
    assign reg_off   = off_full[3:0];
    assign rd_hit    = (off_full[31:4] == '0) && (off_full[1:0] == 2'b00);
    assign wr_hit    = mem_write && rd_hit;
    assign tohost_wr = wr_hit && (reg_off == OFF_TOHOST);
    assign char_wr   = wr_hit && (reg_off == OFF_CHAR);

    always_comb begin
        state_d     = state_q;
        fail_code_d = fail_code_q;
        case (state_q)
            ST_RUN: begin
                // A terminating store outranks a timeout in the same cycle.
                if (tohost_wr && (write_data == 32'd1)) begin
                    state_d = ST_DONE_PASS;
                end else if (tohost_wr && write_data[0]) begin
                    state_d     = ST_DONE_FAIL;
                    fail_code_d = write_data[31:1];
                end else if (TIMEOUT_EN && (cycle_q == TO_LAST)) begin
                    state_d = ST_TIMEOUT;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    always_comb begin
        cycle_d    = (state_q == ST_RUN) ? cycle_q + 32'd1 : cycle_q;
        overflow_d = overflow_q | fifo_drop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            fail_code_q <= '0;
            cycle_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            fail_code_q <= fail_code_d;
            cycle_q     <= cycle_d;
            overflow_q  <= overflow_d;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_char_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (char_wr),
        .push_data_i (write_data[7:0]),
        .ready_i     (char_ready),
        .valid_o     (char_valid),
        .data_o      (char_data),
        .count_o     (fifo_count),
        .drop_o      (fifo_drop)
    );

    assign done        = (state_q != ST_RUN);
    assign pass        = (state_q == ST_DONE_PASS);
    assign timeout     = (state_q == ST_TIMEOUT);
    assign fail_code   = fail_code_q;
    assign cycle_count = cycle_q;
    assign overflow    = overflow_q;
    assign cnt5        = 5'(fifo_count);

    always_comb begin
        rd_data = '0;
        if (rd_hit) begin
            case (reg_off)
                OFF_CYCLE:  rd_data = cycle_q;
                OFF_STATUS: rd_data = pack_status(done, pass,
                                                  (state_q == ST_DONE_FAIL),
                                                  timeout, overflow_q, cnt5);
                default:    rd_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_sim_status_mmio.sv
// Directed bench for sim_status_mmio: termination states, cycle counter,
// timeout, character FIFO ordering/overflow, decode and asynchronous reset.
module tb_sim_status_mmio;

  localparam logic [31:0] BASE = 32'hFFFF_FF00;

  logic        clk;
  logic        rst_n;
  logic        mem_write;
  logic [31:0] data_addr;
  logic [31:0] write_data;
  logic [31:0] rd_data;
  logic        rd_hit;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [30:0] fail_code;
  logic [31:0] cycle_count;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready;
  logic        overflow;

  logic        rst_n_t;
  logic        mw_t;
  logic [31:0] addr_t;
  logic [31:0] wd_t;
  logic [31:0] rd_data_t;
  logic        rd_hit_t;
  logic        done_t;
  logic        pass_t;
  logic        timeout_t;
  logic [30:0] fail_code_t;
  logic [31:0] cycle_count_t;
  logic        char_valid_t;
  logic [7:0]  char_data_t;
  logic        char_ready_t;
  logic        overflow_t;

  int n_cmp;
  int n_mis;
  logic [7:0] exp_q[$];

  sim_status_mmio u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_write   (mem_write),
    .data_addr   (data_addr),
    .write_data  (write_data),
    .rd_data     (rd_data),
    .rd_hit      (rd_hit),
    .done        (done),
    .pass        (pass),
    .timeout     (timeout),
    .fail_code   (fail_code),
    .cycle_count (cycle_count),
    .char_valid  (char_valid),
    .char_data   (char_data),
    .char_ready  (char_ready),
    .overflow    (overflow)
  );

  sim_status_mmio #(.TIMEOUT_CYCLES(10)) u_dut_to (
    .clk         (clk),
    .rst_n       (rst_n_t),
    .mem_write   (mw_t),
    .data_addr   (addr_t),
    .write_data  (wd_t),
    .rd_data     (rd_data_t),
    .rd_hit      (rd_hit_t),
    .done        (done_t),
    .pass        (pass_t),
    .timeout     (timeout_t),
    .fail_code   (fail_code_t),
    .cycle_count (cycle_count_t),
    .char_valid  (char_valid_t),
    .char_data   (char_data_t),
    .char_ready  (char_ready_t),
    .overflow    (overflow_t)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // drivers: inputs change on the falling edge, results sampled on a later one
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    mem_write  = 1'b1;
    data_addr  = addr;
    write_data = data;
    @(negedge clk);
    mem_write  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    mem_write  = 1'b0;
    char_ready = 1'b0;
    data_addr  = '0;
    write_data = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic read(input logic [31:0] addr, input string tag, input logic [31:0] exp);
    data_addr = addr;
    #1;
    chk(tag, rd_data, exp);
  endtask

  task automatic drain(input string tag, input int exp_n);
    int got;
    int guard;
    got   = 0;
    guard = 0;
    char_ready = 1'b1;
    while (char_valid && guard < 20) begin
      if (exp_q.size() > 0) chk(tag, {24'b0, char_data}, {24'b0, exp_q.pop_front()});
      else chk({tag, "_extra"}, {24'b0, char_data}, 32'hFFFF_FFFF);
      got++;
      guard++;
      @(negedge clk);
    end
    char_ready = 1'b0;
    chk({tag, "_count"}, got, exp_n);
    chk({tag, "_empty"}, char_valid, 1'b0);
    exp_q.delete();
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    rst_n = 1'b0;
    mem_write = 1'b0;
    data_addr = '0;
    write_data = '0;
    char_ready = 1'b0;
    rst_n_t = 1'b0;
    mw_t = 1'b0;
    addr_t = '0;
    wd_t = '0;
    char_ready_t = 1'b0;

    // reset state and idle counting
    #2;
    chk("rst_done", done, 1'b0);
    chk("rst_cycle", cycle_count, 32'd0);
    chk("rst_valid", char_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(20);
    chk("idle_done", done, 1'b0);
    chk("idle_cycle", cycle_count, 32'd20);
    read(BASE + 32'h8, "rd_cycle20", 32'd20);
    chk("rd_hit_cycle", rd_hit, 1'b1);
    read(BASE + 32'hC, "rd_status_run", 32'h0);

    // pass at cycle 50, then frozen
    idle(30);
    chk("pre_pass_cycle", cycle_count, 32'd50);
    store(BASE, 32'd1);
    chk("pass", pass, 1'b1);
    chk("pass_done", done, 1'b1);
    chk("pass_cycle", cycle_count, 32'd51);
    idle(5);
    chk("frozen_cycle", cycle_count, 32'd51);
    store(BASE, 32'd7);
    chk("pass_sticky", pass, 1'b1);
    chk("pass_fail_code", {1'b0, fail_code}, 32'd0);
    read(BASE + 32'hC, "rd_status_pass", 32'h3);

    // even store ignored, odd store fails
    do_reset();
    store(BASE, 32'd2);
    chk("even_no_effect", done, 1'b0);
    store(BASE, 32'h15);
    chk("fail_done", done, 1'b1);
    chk("fail_pass", pass, 1'b0);
    chk("fail_code", {1'b0, fail_code}, 32'hA);
    read(BASE + 32'hC, "rd_status_fail", 32'h5);
    store(BASE, 32'd1);
    chk("fail_sticky", pass, 1'b0);
    chk("fail_code_frozen", {1'b0, fail_code}, 32'hA);

    // timeout instance
    @(negedge clk);
    rst_n_t = 1'b1;
    idle(9);
    chk("to_pre", timeout_t, 1'b0);
    chk("to_pre_cycle", cycle_count_t, 32'd9);
    idle(1);
    chk("to_hit", timeout_t, 1'b1);
    chk("to_done", done_t, 1'b1);
    chk("to_cycle", cycle_count_t, 32'd10);
    idle(3);
    chk("to_frozen", cycle_count_t, 32'd10);
    rst_n_t = 1'b0;
    @(negedge clk);
    rst_n_t = 1'b1;
    idle(9);
    mw_t = 1'b1;
    addr_t = BASE;
    wd_t = 32'd1;
    @(negedge clk);
    mw_t = 1'b0;
    chk("to_race_pass", pass_t, 1'b1);
    chk("to_race_timeout", timeout_t, 1'b0);
    chk("to_race_cycle", cycle_count_t, 32'd10);

    // character stream with overflow
    do_reset();
    exp_q.push_back("H");
    exp_q.push_back("i");
    store(BASE + 32'h4, 32'h48);
    store(BASE + 32'h4, 32'h69);
    chk("char_head_early", {24'b0, char_data}, 32'h48);
    for (int i = 0; i < 8; i++) begin
      store(BASE + 32'h4, 32'h61 + i);
      if (i < 6) exp_q.push_back(8'h61 + 8'(i));
      if (i == 5) chk("ovf_at_full", overflow, 1'b0);
    end
    chk("ovf_set", overflow, 1'b1);
    chk("char_head", {24'b0, char_data}, 32'h48);
    read(BASE + 32'hC, "rd_status_full", 32'h280);
    drain("drain1", 8);
    chk("ovf_sticky", overflow, 1'b1);

    // push into full FIFO alongside a pop
    do_reset();
    for (int i = 0; i < 8; i++) begin
      store(BASE + 32'h4, 32'h30 + i);
      if (i > 0) exp_q.push_back(8'h30 + 8'(i));
    end
    exp_q.push_back("X");
    mem_write  = 1'b1;
    data_addr  = BASE + 32'h4;
    write_data = 32'h58;
    char_ready = 1'b1;
    @(negedge clk);
    mem_write  = 1'b0;
    char_ready = 1'b0;
    chk("fullpop_ovf", overflow, 1'b0);
    read(BASE + 32'hC, "rd_status_fullpop", 32'h80);
    chk("fullpop_head", {24'b0, char_data}, 32'h31);
    drain("drain2", 8);

    // decode: misaligned, out of window, read-only registers
    store(BASE + 32'h2, 32'd1);
    chk("misaligned_done", done, 1'b0);
    store(BASE + 32'h6, 32'h41);
    chk("misaligned_char", char_valid, 1'b0);
    store(BASE + 32'h10, 32'd1);
    chk("outside_done", done, 1'b0);
    store(BASE + 32'hC, 32'd1);
    chk("status_wr_ignored", done, 1'b0);
    data_addr = BASE + 32'h2;
    #1;
    chk("rd_hit_misaligned", rd_hit, 1'b0);
    data_addr = BASE + 32'h10;
    #1;
    chk("rd_hit_outside", rd_hit, 1'b0);
    read(BASE, "rd_tohost_zero", 32'h0);
    chk("rd_hit_tohost", rd_hit, 1'b1);

    // asynchronous reset mid-stream
    store(BASE + 32'h4, 32'h41);
    store(BASE + 32'h4, 32'h42);
    store(BASE, 32'd3);
    chk("pre_rst_valid", char_valid, 1'b1);
    chk("pre_rst_code", {1'b0, fail_code}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_done", done, 1'b0);
    chk("arst_code", {1'b0, fail_code}, 32'd0);
    chk("arst_cycle", cycle_count, 32'd0);
    chk("arst_valid", char_valid, 1'b0);
    chk("arst_data", {24'b0, char_data}, 32'd0);
    chk("arst_ovf", overflow, 1'b0);
    read(BASE + 32'hC, "arst_status", 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/sim_status_mmio.md
Name: sim_status_mmio

Overview:
- Memory-mapped status/console peripheral that consumes the core's data-side store bus (mem_write, data_addr, write_data). It sits downstream of the core, alongside data memory.
- Decodes a small register window and provides:
  - sticky pass/fail/timeout termination status, so benches poll one signal instead of decoding stores;
  - a run-cycle counter;
  - a buffered character stream with a valid/ready handshake.

Parameters:
- BASE_ADDR, 32'hFFFF_FF00, word-aligned base of the 16-byte register window.
- TIMEOUT_CYCLES, 100000, cycles in RUN before forced TIMEOUT; 0 disables the timeout.
- FIFO_DEPTH, 8, character FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- mem_write  input  1  store strobe from core.
- data_addr  input  32  store/load address from core.
- write_data  input  32  store data from core.
- rd_data  output  32  combinational read data for loads hitting the window; 0 otherwise.
- rd_hit  output  1  data_addr is inside the window and word-aligned.
- done  output  1  state is not RUN.
- pass  output  1  state is DONE_PASS.
- timeout  output  1  state is TIMEOUT.
- fail_code  output  31  write_data[31:1] captured on the failing TOHOST store.
- cycle_count  output  32  cycles spent in RUN.
- char_valid  output  1  FIFO non-empty.
- char_data  output  8  FIFO head byte.
- char_ready  input  1  consumer accepts head when char_valid is high.
- overflow  output  1  sticky flag: a CHAR push was dropped.

Behaviour:
- Reset (async assert, sync release): state=RUN. All outputs 0, FIFO empty, cycle_count=0, fail_code=0, overflow=0.
- Window decode: hit = mem_write && addr in [BASE_ADDR, BASE_ADDR+15] && addr[1:0]==0.
  - Misaligned or out-of-window stores are ignored.
- Register offsets:
  - 0x0 TOHOST (W)
  - 0x4 CHAR (W)
  - 0x8 CYCLE (R)
  - 0xC STATUS (R)
- Writes to CYCLE or STATUS are ignored.
- State machine: RUN, DONE_PASS, DONE_FAIL, TIMEOUT.
  - RUN, TOHOST store with wdata==1: go to DONE_PASS.
  - RUN, TOHOST store with wdata odd and !=1: go to DONE_FAIL; fail_code <= wdata[31:1].
  - RUN, TOHOST store with wdata even: no effect.
  - RUN, TIMEOUT_CYCLES!=0 and cycle_count==TIMEOUT_CYCLES-1 with no terminating store in that cycle: go to TIMEOUT.
  - A TOHOST store in the same cycle as the timeout wins.
  - Terminal states are sticky until reset. Later TOHOST stores are ignored and fail_code is frozen.
- Status outputs are registered: they are visible the cycle after the store's posedge.
- cycle_count increments by 1 each cycle while in RUN and freezes in terminal states. It wraps at 2^32 with no flag.
- CHAR FIFO:
  - Push write_data[7:0] on a CHAR store.
  - Pop when char_valid && char_ready.
  - Full with no pop: the push is dropped and overflow <= 1 (sticky).
  - Full with a simultaneous pop: the push is accepted.
  - Empty with a simultaneous push: the pop is not possible; char_valid rises the next cycle.
  - CHAR pushes are still accepted in terminal states.
  - Occupancy width: $clog2(FIFO_DEPTH)+1.
- Reads, combinational on data_addr regardless of mem_write:
  - CYCLE: rd_data = cycle_count.
  - STATUS: rd_data = {22'b0, overflow, fifo_count[4:0] zero-extended/truncated, timeout, done&!pass&!timeout, pass, done}. fifo_count is truncated to 5 bits.
  - TOHOST and CHAR read 0.
- Reset asserted mid-operation clears the FIFO contents and all state immediately.

Decomposition:
- Package sim_status_pkg:
  - offset constants OFF_TOHOST/OFF_CHAR/OFF_CYCLE/OFF_STATUS;
  - state_e enum (2-bit);
  - STATUS bit-position constants.
- Sub-module: sync_fifo, parameterised width/depth, with the same async active-low reset, a count output, and a full-with-pop accept rule. Instantiated with width 8.

Test Plan:
- Reset, then idle 20 cycles -> done=0, cycle_count=20; a load of BASE+8 returns 20 on rd_data.
- Store 1 to BASE+0 at cycle 50 -> pass=1, done=1 next cycle; cycle_count frozen at 51; a later store of 7 to TOHOST leaves pass=1, fail_code=0.
- Store 0x15 to TOHOST -> DONE_FAIL, fail_code=0xA, STATUS reads 0x5 with FIFO empty; a store of 2 to TOHOST beforehand has no effect.
- Parameters TIMEOUT_CYCLES=10, no stores -> timeout=1 after exactly 10 cycles, cycle_count=10. Repeat with TOHOST=1 at the timeout cycle -> pass=1, timeout=0.
- Char stream, char_ready=0:
  - store 'H','i' then 8 more CHAR stores with FIFO_DEPTH=8 -> overflow=1, char_data='H';
  - raise char_ready -> bytes drain in order, 8 total;
  - push while full with char_ready=1 -> no overflow change, byte accepted.
- Store to BASE+2 (misaligned) and to BASE+16 -> no state change, rd_hit=0. Assert rst_n low mid-stream -> FIFO empty and all outputs 0 immediately, with no clock edge required.
